// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution slice.
//   - funct3 encodings understood by the comparitor
//   - FSM state encoding for branch_resolve_ctrl
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Issue / result / redirect bundle of branch_resolve_ctrl.
//   slave  : the controller (consumes ops and redirect_ready, drives results)
//   master : issue + fetch side
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;

    logic            res_valid;
    logic            res_taken;
    logic            res_mispredict;
    logic            res_misalign;

    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport slave (
        input  in_valid, in_funct3, in_a, in_b, in_pc, in_imm, in_pred_taken,
        input  redirect_ready,
        output in_ready,
        output res_valid, res_taken, res_mispredict, res_misalign,
        output redirect_valid, redirect_pc, flush
    );

    modport master (
        output in_valid, in_funct3, in_a, in_b, in_pc, in_imm, in_pred_taken,
        output redirect_ready,
        input  in_ready,
        input  res_valid, res_taken, res_mispredict, res_misalign,
        input  redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/branch_resolve_ctrl_comparitor.sv
// Branch condition comparitor.
//   a, b : operands
//   ctrl : branch funct3; unlisted encodings (010/011) behave as beq
//   y    : branch taken
module comparitor
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic            y
);
    always_comb begin
        y = (a == b);
        case (ctrl)
            BNE:     y = (a != b);
            BLT:     y = ($signed(a) <  $signed(b));
            BGE:     y = ($signed(a) >= $signed(b));
            BLTU:    y = (a <  b);
            BGEU:    y = (a >= b);
            default: y = (a == b);
        endcase
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution controller.
//   clk, rst        : clock, synchronous active-high reset
//   kill            : older-instruction flush, aborts the op in flight
//   bus             : op handshake, 1-cycle result pulse, redirect handshake
//   cnt_branches    : saturating count of non-misaligned resolves
//   cnt_mispredict  : saturating count of mispredicts
// Ops are registered on accept and resolved in the following (EVAL) cycle.
// A mispredict parks the FSM in REDIRECT until fetch takes the redirect.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    branch_resolve_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     cnt_branches,
    output logic [CNT_W-1:0]     cnt_mispredict
);
    state_t          state_q, state_d;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] op_a, op_b, op_pc, op_imm;
    logic            op_pred;

    logic            taken, misalign, mispred, eval, accept;
    logic [XLEN-1:0] target;

    comparitor #(.XLEN(XLEN)) u_cmp (
        .a    (op_a),
        .b    (op_b),
        .ctrl (op_f3),
        .y    (taken)
    );

    // Op registers stay untouched in REDIRECT (in_ready=0), so the target
    // computed from them is stable for the whole redirect request.
    always_comb begin
        target   = taken ? (op_pc + op_imm) : (op_pc + XLEN'(4));
        misalign = taken & (target[1:0] != 2'b00);
        mispred  = (taken != op_pred) & ~misalign;
        eval     = (state_q == EVAL) & ~kill;
    end

    always_comb begin
        state_d            = state_q;
        bus.in_ready       = 1'b0;
        bus.res_valid      = eval;
        bus.res_taken      = eval & taken;
        bus.res_mispredict = eval & mispred;
        bus.res_misalign   = eval & misalign;
        bus.redirect_valid = (state_q == REDIRECT) & ~kill;
        bus.redirect_pc    = bus.redirect_valid ? target : '0;
        bus.flush          = bus.redirect_valid & bus.redirect_ready;

        case (state_q)
            IDLE:     bus.in_ready = 1'b1;
            EVAL:     bus.in_ready = ~misalign & ~mispred;
            default:  bus.in_ready = 1'b0;
        endcase
        if (kill) bus.in_ready = 1'b0;

        accept = bus.in_valid & bus.in_ready;

        case (state_q)
            IDLE:     if (accept) state_d = EVAL;
            EVAL: begin
                if (misalign)     state_d = IDLE;
                else if (mispred) state_d = REDIRECT;
                else if (accept)  state_d = EVAL;
                else              state_d = IDLE;
            end
            REDIRECT: if (bus.redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            op_f3          <= '0;
            op_a           <= '0;
            op_b           <= '0;
            op_pc          <= '0;
            op_imm         <= '0;
            op_pred        <= 1'b0;
            cnt_branches   <= '0;
            cnt_mispredict <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_f3   <= bus.in_funct3;
                op_a    <= bus.in_a;
                op_b    <= bus.in_b;
                op_pc   <= bus.in_pc;
                op_imm  <= bus.in_imm;
                op_pred <= bus.in_pred_taken;
            end
            // Saturate at all-ones: add 1 only while not already full.
            if (eval && !misalign && cnt_branches != '1)
                cnt_branches <= cnt_branches + CNT_W'(1);
            if (eval && mispred && cnt_mispredict != '1)
                cnt_mispredict <= cnt_mispredict + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: expected outcomes are queued as ops
// are driven and popped when the result pulse appears.
module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, kill;
    logic [15:0] cnt_br, cnt_mp;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.XLEN(32)) bus ();

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .kill           (kill),
        .bus            (bus),
        .cnt_branches   (cnt_br),
        .cnt_mispredict (cnt_mp)
    );

    typedef struct {
        logic taken;
        logic mis;
        logic mal;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        #4;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                         input logic push, input logic e_t, input logic e_mis, input logic e_mal);
        exp_t e;
        bus.in_valid      = 1'b1;
        bus.in_funct3     = f3;
        bus.in_a          = a;
        bus.in_b          = b;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_pred_taken = pred;
        if (push) begin
            e.taken = e_t; e.mis = e_mis; e.mal = e_mal;
            sb.push_back(e);
        end
    endtask

    task automatic check_res(input string tag);
        exp_t e;
        chk({tag, ".res_valid"}, {31'd0, bus.res_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".taken"},    {31'd0, bus.res_taken},      {31'd0, e.taken});
            chk({tag, ".mispred"},  {31'd0, bus.res_mispredict}, {31'd0, e.mis});
            chk({tag, ".misalign"}, {31'd0, bus.res_misalign},   {31'd0, e.mal});
        end
    endtask

    // Called at the sample point of an EVAL cycle that mispredicted.
    task automatic take_redirect(input string tag, input logic [31:0] rpc);
        step(); samp();
        chk({tag, ".rv"},  {31'd0, bus.redirect_valid}, 32'd1);
        chk({tag, ".rpc"}, bus.redirect_pc, rpc);
        bus.redirect_ready = 1'b1;
        #1;
        chk({tag, ".flush"}, {31'd0, bus.flush}, 32'd1);
        step();
        bus.redirect_ready = 1'b0;
        samp();
        chk({tag, ".rv_off"},   {31'd0, bus.redirect_valid}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready},       32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; kill = 1'b0;
        bus.in_valid = 1'b0; bus.redirect_ready = 1'b0;
        bus.in_funct3 = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_pc = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0;

        // Reset state
        step(); step(); samp();
        chk("rst.in_ready", {31'd0, bus.in_ready},       32'd1);
        chk("rst.res_valid",{31'd0, bus.res_valid},      32'd0);
        chk("rst.rv",       {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst.cnt_br",   {16'd0, cnt_br},             32'd0);
        chk("rst.cnt_mp",   {16'd0, cnt_mp},             32'd0);
        step(); rst = 1'b0;

        // 1: beq taken, predicted taken
        drive(BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("t1");
        chk("t1.rv", {31'd0, bus.redirect_valid}, 32'd0);
        step(); samp();
        chk("t1.cnt_br", {16'd0, cnt_br}, 32'd1);

        // 2: blt taken, predicted not-taken; redirect held for 3 cycles
        drive(BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("t2");
        chk("t2.in_ready_eval", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); samp();
            chk("t2.rv_hold",  {31'd0, bus.redirect_valid}, 32'd1);
            chk("t2.rpc_hold", bus.redirect_pc, 32'h1F8);
            chk("t2.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("t2.noflush",  {31'd0, bus.flush}, 32'd0);
        end
        bus.redirect_ready = 1'b1;
        #1;
        chk("t2.flush", {31'd0, bus.flush}, 32'd1);
        step(); bus.redirect_ready = 1'b0; samp();
        chk("t2.rv_off",   {31'd0, bus.redirect_valid}, 32'd0);
        chk("t2.flush_off",{31'd0, bus.flush}, 32'd0);
        chk("t2.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t2.cnt_br",   {16'd0, cnt_br}, 32'd2);
        chk("t2.cnt_mp",   {16'd0, cnt_mp}, 32'd1);

        // 3: bltu not taken, predicted taken
        drive(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("t3");
        take_redirect("t3", 32'h304);

        // 4: bge taken to a misaligned target; mispredict suppressed
        drive(BGE, 32'd1, 32'd1, 32'h400, 32'h2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(); bus.in_valid = 1'b0; samp();
        check_res("t4");
        chk("t4.rv", {31'd0, bus.redirect_valid}, 32'd0);
        step(); samp();
        chk("t4.rv_next",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("t4.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t4.cnt_br",   {16'd0, cnt_br}, 32'd3);
        chk("t4.cnt_mp",   {16'd0, cnt_mp}, 32'd2);

        // 4b: not-taken fall-through wraps past 2^32
        drive(BGE, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("wrap");
        take_redirect("wrap", 32'h0);

        // funct3 010 behaves as beq
        drive(3'b010, 32'd7, 32'd7, 32'h800, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("f3_010");
        step(); samp();
        chk("f3_010.cnt_br", {16'd0, cnt_br}, 32'd5);

        // 5: four back-to-back correctly predicted bne
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                drive(BNE, 32'd10, 32'(i), 32'h900 + 32'(i * 4), 32'h8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            else
                bus.in_valid = 1'b0;
            #1;
            if (i < 4) chk("t5.in_ready", {31'd0, bus.in_ready}, 32'd1);
            if (i > 0) check_res("t5");
            step();
        end
        samp();
        chk("t5.cnt_br", {16'd0, cnt_br}, 32'd9);
        chk("t5.cnt_mp", {16'd0, cnt_mp}, 32'd3);

        // Drive the branch counter into saturation, with 3 ops to spare
        drive(BNE, 32'd1, 32'd2, 32'h1000, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65529) step();
        bus.in_valid = 1'b0;
        step(); samp();
        chk("sat.cnt_br", {16'd0, cnt_br}, 32'h0000_FFFF);
        chk("sat.cnt_mp", {16'd0, cnt_mp}, 32'd3);

        // 6: kill while in REDIRECT
        drive(BEQ, 32'd1, 32'd2, 32'h500, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(); bus.in_valid = 1'b0; samp();
        check_res("t6");
        step(); samp();
        chk("t6.rv", {31'd0, bus.redirect_valid}, 32'd1);
        step(); kill = 1'b1; bus.redirect_ready = 1'b1; samp();
        chk("t6.kill_rv",    {31'd0, bus.redirect_valid}, 32'd0);
        chk("t6.kill_flush", {31'd0, bus.flush}, 32'd0);
        chk("t6.kill_rdy",   {31'd0, bus.in_ready}, 32'd0);
        step(); kill = 1'b0; bus.redirect_ready = 1'b0; samp();
        chk("t6.rv_after",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("t6.in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("t6.cnt_mp",    {16'd0, cnt_mp}, 32'd4);

        // kill in EVAL: result suppressed, mispredict not counted
        drive(BEQ, 32'd3, 32'd3, 32'h600, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); bus.in_valid = 1'b0; kill = 1'b1; samp();
        chk("kev.res_valid", {31'd0, bus.res_valid}, 32'd0);
        step(); kill = 1'b0; samp();
        chk("kev.rv",     {31'd0, bus.redirect_valid}, 32'd0);
        chk("kev.cnt_mp", {16'd0, cnt_mp}, 32'd4);

        // rst in EVAL
        drive(BEQ, 32'd3, 32'd3, 32'h700, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); bus.in_valid = 1'b0; rst = 1'b1;
        step(); samp();
        chk("rev.res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rev.rv",        {31'd0, bus.redirect_valid}, 32'd0);
        chk("rev.in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("rev.cnt_br",    {16'd0, cnt_br}, 32'd0);
        chk("rev.cnt_mp",    {16'd0, cnt_mp}, 32'd0);
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
